// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution operation controller.
package conv_pkg;
  localparam int ELEM_W   = 8;
  localparam int N_TAPS   = 9;
  localparam int RESULT_W = 20;
  localparam int BUS_W    = 72;

  localparam logic [1:0] OP_NOP         = 2'b00;
  localparam logic [1:0] OP_LOAD_KERNEL = 2'b01;
  localparam logic [1:0] OP_START       = 2'b10;
  localparam logic [1:0] OP_CLEAR       = 2'b11;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;
endpackage

// File: rtl/mac_unit.sv
// One multiply-accumulate tap: unsigned pixel times signed weight, added to a
// 20-bit running sum.
module mac_unit
  import conv_pkg::*;
(
  input  logic [ELEM_W-1:0]   pixel,
  input  logic [ELEM_W-1:0]   weight,
  input  logic [RESULT_W-1:0] acc_in,
  output logic [RESULT_W-1:0] acc_out
);
  logic signed [ELEM_W:0]   pixel_s;
  logic signed [ELEM_W-1:0] weight_s;
  logic signed [2*ELEM_W:0] product;

  // Zero-extend the pixel to 9 bits so it multiplies as a non-negative signed value.
  assign pixel_s  = {1'b0, pixel};
  assign weight_s = weight;
  assign product  = pixel_s * weight_s;
  assign acc_out  = acc_in + {{(RESULT_W-2*ELEM_W-1){product[2*ELEM_W]}}, product};
endmodule

// File: rtl/op_ctrl.sv
// Operation controller: decodes opcodes, holds kernel/window byte arrays and
// sequences a 9-tap MAC, one tap per cycle.
module op_ctrl
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                select,
  input  logic [1:0]          opcode,
  input  logic [BUS_W-1:0]    bus,
  output logic [RESULT_W-1:0] result,
  output logic                done,
  output logic                busy
);
  localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);

  logic [ELEM_W-1:0]   bus_elem   [N_TAPS];
  logic [ELEM_W-1:0]   kernel_reg [N_TAPS];
  logic [ELEM_W-1:0]   window_reg [N_TAPS];
  logic [RESULT_W-1:0] acc_reg;
  logic [RESULT_W-1:0] result_reg;
  logic [RESULT_W-1:0] mac_out;
  logic [3:0]          tap_reg;
  logic                done_reg;
  state_t              state_reg, state_next;

  logic clear_cmd, load_kernel, start_cmd, step, finish;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_bus_split
      assign bus_elem[gi] = bus[BUS_W-1-ELEM_W*gi -: ELEM_W];
    end
  endgenerate

  assign clear_cmd = select && (opcode == OP_CLEAR);

  always_comb begin
    state_next  = state_reg;
    load_kernel = 1'b0;
    start_cmd   = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    if (clear_cmd) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (select && opcode == OP_LOAD_KERNEL) load_kernel = 1'b1;
          if (select && opcode == OP_START) begin
            start_cmd  = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          step = 1'b1;
          if (tap_reg == LAST_TAP) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Kernel and window are only written while idle, so they stay stable through a MAC.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TAPS; i++) begin
      if (rst) begin
        kernel_reg[i] <= '0;
        window_reg[i] <= '0;
      end else begin
        if (load_kernel) kernel_reg[i] <= bus_elem[i];
        if (start_cmd)   window_reg[i] <= bus_elem[i];
      end
    end
  end

  mac_unit u_mac (
    .pixel  (window_reg[tap_reg]),
    .weight (kernel_reg[tap_reg]),
    .acc_in (acc_reg),
    .acc_out(mac_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      tap_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= finish;
      if (clear_cmd) begin
        acc_reg    <= '0;
        tap_reg    <= '0;
        result_reg <= '0;
      end else if (start_cmd) begin
        acc_reg <= '0;
        tap_reg <= '0;
      end else if (step) begin
        acc_reg <= mac_out;
        tap_reg <= 4'(tap_reg + 4'd1);
        if (finish) begin
          result_reg <= mac_out;
          tap_reg    <= '0;
        end
      end
    end
  end

  assign result = result_reg;
  assign done   = done_reg;
  assign busy   = (state_reg == RUN);
endmodule

// File: tb/tb_op_ctrl.sv
// Self-checking bench for op_ctrl: directed scenarios plus random traffic,
// all compared against a countdown-based behavioural model.
module tb_op_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        select;
  logic [1:0]  opcode;
  logic [71:0] bus;
  logic [19:0] result;
  logic        done;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_kern [9];
  int m_win  [9];
  int m_cnt;
  int m_result;
  int m_done;

  op_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .select(select),
    .opcode(opcode),
    .bus   (bus),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int conv_sum();
    int s = 0;
    for (int k = 0; k < 9; k++) s += m_win[k] * m_kern[k];
    return s;
  endfunction

  function automatic int byte_at(input logic [71:0] b, input int k, input bit is_signed);
    logic [7:0] v;
    v = b[71-8*k -: 8];
    return is_signed ? int'($signed(v)) : int'(v);
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic [1:0] op, input logic [71:0] b);
    if (r) begin
      for (int k = 0; k < 9; k++) begin m_kern[k] = 0; m_win[k] = 0; end
      m_cnt = 0; m_result = 0; m_done = 0;
    end else if (s && op == 2'b11) begin
      m_cnt = 0; m_result = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_result = conv_sum();
          m_done   = 1;
        end
      end else if (s && op == 2'b01) begin
        for (int k = 0; k < 9; k++) m_kern[k] = byte_at(b, k, 1'b1);
      end else if (s && op == 2'b10) begin
        for (int k = 0; k < 9; k++) m_win[k] = byte_at(b, k, 1'b0);
        m_cnt = 9;
      end
    end
  endtask

  // One clock: drive on negedge, update model at posedge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic s, input logic [1:0] op, input logic [71:0] b);
    @(negedge clk);
    rst = r; select = s; opcode = op; bus = b;
    @(posedge clk);
    model_edge(r, s, op, b);
    #1;
    check("busy", 32'(busy), 32'(m_cnt > 0));
    check("done", 32'(done), 32'(m_done));
    check("result", 32'(result), 32'(m_result) & 32'hFFFFF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 72'h0);
  endtask

  localparam logic [71:0] WIN_SEQ = 72'h010203040506070809;
  localparam logic [71:0] K_ONES  = 72'h010101010101010101;
  localparam logic [71:0] K_NEG   = 72'hFFFFFFFFFFFFFFFFFF;
  localparam logic [71:0] K_MIN   = 72'h808080808080808080;
  localparam logic [71:0] W_MAX   = 72'hFFFFFFFFFFFFFFFFFF;

  initial begin
    int busy_cycles;
    rst = 1'b1; select = 1'b0; opcode = 2'b00; bus = '0;
    m_cnt = 0; m_result = 0; m_done = 0;
    for (int k = 0; k < 9; k++) begin m_kern[k] = 0; m_win[k] = 0; end

    // Reset priority: LOAD_KERNEL during reset must be discarded.
    cycle(1'b1, 1'b1, 2'b01, WIN_SEQ);
    check("reset_result", 32'(result), 32'h0);
    cycle(1'b0, 1'b1, 2'b10, WIN_SEQ);
    idle(8);
    check("rstprio_nodone_early", 32'(done), 32'h0);
    idle(1);
    check("rstprio_done", 32'(done), 32'h1);
    check("rstprio_result", 32'(result), 32'h0);

    // Basic sum and busy duration.
    cycle(1'b0, 1'b1, 2'b01, K_ONES);
    cycle(1'b0, 1'b1, 2'b10, WIN_SEQ);
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy) busy_cycles++;
      idle(1);
    end
    check("basic_busy_len", 32'(busy_cycles), 32'd9);
    check("basic_done", 32'(done), 32'h1);
    check("basic_sum", 32'(result), 32'h0002D);

    // Signed arithmetic.
    cycle(1'b0, 1'b1, 2'b01, K_NEG);
    cycle(1'b0, 1'b1, 2'b10, WIN_SEQ);
    idle(9);
    check("signed_neg45", 32'(result), 32'hFFFD3);
    cycle(1'b0, 1'b1, 2'b01, K_MIN);
    cycle(1'b0, 1'b1, 2'b10, W_MAX);
    idle(9);
    check("signed_min", 32'(result), 32'hB8480);

    // Busy lockout: START at N+3, LOAD_KERNEL at N+5 both ignored.
    cycle(1'b0, 1'b1, 2'b01, K_ONES);
    cycle(1'b0, 1'b1, 2'b10, WIN_SEQ);
    idle(2);
    cycle(1'b0, 1'b1, 2'b10, W_MAX);
    idle(1);
    cycle(1'b0, 1'b1, 2'b01, K_NEG);
    idle(4);
    check("lockout_result", 32'(result), 32'h0002D);
    cycle(1'b0, 1'b1, 2'b10, WIN_SEQ);
    idle(9);
    check("lockout_kernel_kept", 32'(result), 32'h0002D);

    // CLEAR at N+4, then no done pulse.
    cycle(1'b0, 1'b1, 2'b10, W_MAX);
    idle(3);
    cycle(1'b0, 1'b1, 2'b11, 72'h0);
    check("clear_busy", 32'(busy), 32'h0);
    check("clear_result", 32'(result), 32'h0);
    idle(8);

    // select=0 gating.
    for (int op = 0; op < 4; op++) cycle(1'b0, 1'b0, 2'(op), W_MAX);
    check("gate_busy", 32'(busy), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [95:0] raw;
      logic [1:0]  op_r;
      int          r;
      raw = {$urandom(), $urandom(), $urandom()};
      r = int'($urandom_range(0, 15));
      op_r = (r == 0) ? 2'b11 : (r <= 5) ? 2'b01 : (r <= 10) ? 2'b10 : 2'b00;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), op_r, raw[71:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
